// File: rtl/sram_port0_ctrl.sv
// sram_port0_ctrl: valid/ready front end for the single RW port of a 1RW SRAM macro.
// Latency: request registered onto macro pins 1 cycle after accept; read data in rsp FIFO 2 cycles after accept.
// Backpressure: req_ready is a credit check (reads in flight + buffered < RSP_DEPTH); rsp side is valid/ready.
//
// Ports:
//   clk0, rst0_n                         clock (shared with the macro's clk0), async active-low reset
//   req_valid/req_ready/req_we/req_addr/req_din   request channel (write when req_we=1)
//   rsp_valid/rsp_ready/rsp_dout         read response channel, oldest first, show-ahead
//   sram_csb0/sram_web0/sram_addr0/sram_din0/sram_dout0   macro RW port pins
//   busy                                 something issued, in flight or buffered

// sram_port0_rsp_fifo: generic show-ahead FIFO with occupancy count.
// Latency: pushed word visible on pop_dat the cycle after the push edge.
// Backpressure: none on push (caller guarantees space); pop only when pop_vld && pop_rdy.
module sram_port0_rsp_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [W-1:0]     pop_dat,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign pop_vld = (cnt_q != '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count   = cnt_q;
  // Storage is reset so the head is a defined value even before the first push.
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push_vld;
  assign do_pop  = pop_vld && pop_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // DEPTH is a power of two, so the natural pointer overflow is the wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end
  end

`ifndef SYNTHESIS
  // The credit check upstream makes this unreachable; firing means lost data.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push_vld && full));
    end
  end
`endif

endmodule

module sram_port0_ctrl #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_din,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_dout,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RSP_DEPTH);

  // Issue stage S1: registered macro pins plus a read marker.
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rd_s1_q, rd_s1_d;
  // S2: the macro sampled a read on the last edge; its data is valid at the next edge.
  logic                  rd_s2_q;

  logic                  accept;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [OCC_W-1:0]      occ;

  // Every read accepted but not yet popped holds a credit. Only registered
  // terms are used so req_ready carries no combinational path from inputs,
  // and a pop frees its credit only on the following cycle.
  assign occ = OCC_W'(rd_s1_q) + OCC_W'(rd_s2_q) + OCC_W'(fifo_cnt);
  // Writes are gated by the same check so req_ready never depends on req_we.
  assign req_ready = (occ < DEPTH_OCC);
  assign accept    = req_valid && req_ready;

  always_comb begin
    csb_d   = 1'b1;
    web_d   = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_s1_d = 1'b0;
    if (accept) begin
      csb_d   = 1'b0;
      web_d   = ~req_we;
      addr_d  = req_addr;
      din_d   = req_din;
      rd_s1_d = ~req_we;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      rd_s1_q <= 1'b0;
      rd_s2_q <= 1'b0;
    end else begin
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_s1_q <= rd_s1_d;
      rd_s2_q <= rd_s1_q;
    end
  end

  assign sram_csb0  = csb_q;
  assign sram_web0  = web_q;
  assign sram_addr0 = addr_q;
  assign sram_din0  = din_q;

  // The macro reads on the negedge after sampling and holds dout until just
  // past the next posedge, so capturing on that posedge sees stable data as
  // long as the macro's read delay is under half a period.
  sram_port0_rsp_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk      (clk0),
    .rst_n    (rst0_n),
    .push_vld (rd_s2_q),
    .push_dat (sram_dout0),
    .pop_rdy  (rsp_ready),
    .pop_vld  (rsp_valid),
    .pop_dat  (rsp_dout),
    .full     (fifo_full),
    .count    (fifo_cnt)
  );

  assign busy = ~csb_q | rd_s2_q | (fifo_cnt != '0);

`ifndef SYNTHESIS
  always @(posedge clk0) begin
    if (rst0_n) begin
      assert (occ <= DEPTH_OCC);
      assert (!(rd_s2_q && fifo_full));
    end
  end
`endif

endmodule

// File: tb/tb_sram_port0_ctrl.sv
module tb_sram_port0_ctrl;

  localparam int DW    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic          clk0 = 1'b0;
  logic          rst0_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_din;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dout;
  logic          sram_csb0;
  logic          sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;
  logic          busy;

  sram_port0_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dout   (rsp_dout),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .busy       (busy)
  );

  always #5 clk0 = ~clk0;

  // Macro model: samples pins at posedge, writes/reads at the following
  // negedge, dout valid from negedge+2 until posedge+1, X otherwise.
  logic [DW-1:0] mem [2**AW];
  logic          m_csb = 1'b1;
  logic          m_web = 1'b1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  always @(posedge clk0) begin
    m_csb  <= sram_csb0;
    m_web  <= sram_web0;
    m_addr <= sram_addr0;
    m_din  <= sram_din0;
  end

  always @(negedge clk0) begin
    if (m_csb == 1'b0 && m_web == 1'b0) mem[m_addr] = m_din;
    if (m_csb == 1'b0 && m_web == 1'b1) begin
      #2;
      sram_dout0 = mem[m_addr];
      @(posedge clk0);
      #1;
      sram_dout0 = 'x;
    end
  end

  // Reference model: contents as seen by the requester, plus a queue of
  // reads not yet consumed, each with the cycle its response becomes visible.
  typedef struct {
    logic [DW-1:0] dat;
    int            avail;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [2**AW];
  int            cyc;
  bit            acc_prev;
  bit            last_we;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;
  int            n_tests;
  int            n_fail;
  int            dut_acc;
  int            dut_pop;
  int            a0;
  int            p0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    acc_prev  = 1'b0;
    last_we   = 1'b0;
    last_addr = '0;
    last_din  = '0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance
  // the model across the posedge using the model's own idea of req_ready.
  task automatic tick();
    bit exp_rdy;
    bit exp_vld;
    bit acc;
    bit pop;
    @(negedge clk0);
    exp_rdy = (q.size() < DEPTH);
    exp_vld = (q.size() != 0) && (q[0].avail <= cyc);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    if (exp_vld) chk("rsp_dout", 32'(rsp_dout), 32'(q[0].dat));
    chk("busy", 32'(busy), 32'(acc_prev || (q.size() != 0)));
    chk("csb", 32'(sram_csb0), 32'(!acc_prev));
    chk("web", 32'(sram_web0), 32'(acc_prev ? !last_we : 1'b1));
    chk("addr_hold", 32'(sram_addr0), 32'(last_addr));
    chk("din_hold", 32'(sram_din0), 32'(last_din));
    acc = rst0_n && req_valid && exp_rdy;
    pop = rst0_n && rsp_ready && exp_vld;
    if (req_valid && req_ready) dut_acc++;
    if (rsp_valid && rsp_ready) dut_pop++;
    @(posedge clk0);
    cyc++;
    if (pop) void'(q.pop_front());
    acc_prev = acc;
    if (acc) begin
      last_we   = req_we;
      last_addr = req_addr;
      last_din  = req_din;
      if (req_we) ref_mem[req_addr] = req_din;
      else q.push_back('{ref_mem[req_addr], cyc + 2});
    end
    #1;
  endtask

  task automatic issue(input bit we, input int addr, input int din);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_din   = DW'(din);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    dut_acc   = 0;
    dut_pop   = 0;
    rst0_n    = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_din   = '0;
    rsp_ready = 1'b0;
    model_reset();

    // Reset state
    idle(2);
    chk("rst_dout", 32'(rsp_dout), 32'h0);
    chk("rst_addr", 32'(sram_addr0), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #2 rst0_n = 1'b1;
    idle(1);

    // Write 3 then read 3: response 2 cycles after acceptance
    rsp_ready = 1'b1;
    issue(1'b1, 3, 2);
    issue(1'b0, 3, 0);
    chk("t1_vld_c0", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_vld_c1", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_vld_c2", 32'(rsp_valid), 32'h1);
    chk("t1_dout", 32'(rsp_dout), 32'h2);
    tick();
    chk("t1_empty", 32'(rsp_valid), 32'h0);
    idle(1);

    // Fill all addresses, then stream reads back to back
    for (int a = 0; a < 16; a++) issue(1'b1, a, a & 3);
    a0 = dut_acc;
    p0 = dut_pop;
    for (int a = 0; a < 16; a++) issue(1'b0, a, 0);
    chk("t2_accepted", 32'(dut_acc - a0), 32'd16);
    idle(4);
    chk("t2_popped", 32'(dut_pop - p0), 32'd16);

    // Read-after-write, consecutive cycles
    issue(1'b1, 5, 1);
    issue(1'b0, 5, 3);
    tick();
    tick();
    chk("raw_vld", 32'(rsp_valid), 32'h1);
    chk("raw_dout", 32'(rsp_dout), 32'h1);
    idle(2);

    // Stalled consumer: exactly DEPTH reads accepted
    rsp_ready = 1'b0;
    a0 = dut_acc;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(i + 4);
      tick();
    end
    req_valid = 1'b0;
    chk("stall_accepted", 32'(dut_acc - a0), 32'd4);
    chk("stall_vld", 32'(rsp_valid), 32'h1);
    chk("stall_rdy", 32'(req_ready), 32'h0);
    idle(2);
    p0 = dut_pop;
    rsp_ready = 1'b1;
    idle(6);
    chk("stall_drained", 32'(dut_pop - p0), 32'd4);

    // Credits exhausted, pop and capture on the same edge
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 8 + i, 0);
    tick();
    p0 = dut_pop;
    rsp_ready = 1'b1;
    tick();
    chk("full_pop1", 32'(dut_pop - p0), 32'd1);
    chk("full_vld", 32'(rsp_valid), 32'h1);
    idle(5);
    chk("full_pop4", 32'(dut_pop - p0), 32'd4);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1);
      req_addr  = AW'($urandom_range(0, 15));
      req_din   = DW'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(8);
    chk("rand_idle", 32'(busy), 32'h0);

    // Reset with two reads in flight
    rsp_ready = 1'b0;
    issue(1'b0, 1, 0);
    issue(1'b0, 2, 0);
    #2 rst0_n = 1'b0;
    #1;
    chk("mrst_csb", 32'(sram_csb0), 32'h1);
    chk("mrst_vld", 32'(rsp_valid), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    model_reset();
    idle(2);
    #2 rst0_n = 1'b1;
    rsp_ready = 1'b1;
    idle(6);
    chk("post_rst_vld", 32'(rsp_valid), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
